// File: rtl/ram_port_arbiter_d0.sv
// ram_port_arbiter_d0: two-port arbiter in front of a sync-read single-port data RAM
//   Port 0 is the processor side, port 1 is the snoop/bus side. One access is granted per
//   cycle; read data returns one cycle later with a per-port rvalid. A granted port may
//   lock the RAM for up to LOCK_MAX consecutive grants (atomic read-modify-write).
//   Optional macro RAM_ARB_FIXED_PRIO_EN: ties in IDLE always go to port 1 instead of round-robin.
// Ports:
//   clock, resetn                       rising-edge clock, synchronous active-low reset
//   pN_req/we/lock/addr/wdata (N=0,1)   request, write enable, lock hold, address, write data
//   pN_gnt                              combinational grant
//   pN_rvalid, pN_rdata                 registered read-data valid, read data (= ram_dout)
//   ram_addr, ram_din, ram_we, ram_dout RAM interface (outputs 0 when nothing is granted)
module ram_port_arbiter_d0 #(
    parameter int AWIDTH   = 3,
    parameter int DWIDTH   = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic              p0_lock,
    input  logic [AWIDTH-1:0] p0_addr,
    input  logic [DWIDTH-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DWIDTH-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic              p1_lock,
    input  logic [AWIDTH-1:0] p1_addr,
    input  logic [DWIDTH-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DWIDTH-1:0] p1_rdata,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_din,
    output logic              ram_we,
    input  logic [DWIDTH-1:0] ram_dout
);
    localparam int CW = $clog2(LOCK_MAX) + 1;
    localparam logic [CW-1:0] LAST = CW'(LOCK_MAX - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] lock_cnt, lock_cnt_nx;
    logic          gnt0, gnt1;
`ifndef RAM_ARB_FIXED_PRIO_EN
    // rr_ptr holds the last tie winner; the other port wins the next tie
    logic          rr_ptr, rr_ptr_nx;
`endif

    always_comb begin
        state_nx    = state;
        lock_cnt_nx = lock_cnt;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
        rr_ptr_nx   = rr_ptr;
`endif
        case (state)
            IDLE: begin
                if (p0_req && p1_req) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                    gnt1 = 1'b1;
`else
                    gnt0      = rr_ptr;
                    gnt1      = !rr_ptr;
                    rr_ptr_nx = !rr_ptr;
`endif
                end else begin
                    gnt0 = p0_req;
                    gnt1 = p1_req;
                end
                if ((gnt0 && p0_lock) || (gnt1 && p1_lock)) begin
                    state_nx    = gnt0 ? OWN0 : OWN1;
                    lock_cnt_nx = CW'(1);
                end
            end
            OWN0: begin
                gnt0 = p0_req;
                if (p0_req && p0_lock && lock_cnt < LAST) begin
                    lock_cnt_nx = lock_cnt + CW'(1);
                end else begin
                    state_nx    = IDLE;
                    lock_cnt_nx = '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
                    // forced release: make port 1 win the next tie
                    if (p0_req && p0_lock) rr_ptr_nx = 1'b0;
`endif
                end
            end
            OWN1: begin
                gnt1 = p1_req;
                if (p1_req && p1_lock && lock_cnt < LAST) begin
                    lock_cnt_nx = lock_cnt + CW'(1);
                end else begin
                    state_nx    = IDLE;
                    lock_cnt_nx = '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
                    if (p1_req && p1_lock) rr_ptr_nx = 1'b1;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
        // no access reaches the RAM while reset is asserted
        if (!resetn) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= IDLE;
            lock_cnt  <= '0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
        end else begin
            state     <= state_nx;
            lock_cnt  <= lock_cnt_nx;
            p0_rvalid <= gnt0 && !p0_we;
            p1_rvalid <= gnt1 && !p1_we;
        end
    end

`ifndef RAM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clock) begin
        if (!resetn) rr_ptr <= 1'b1;
        else         rr_ptr <= rr_ptr_nx;
    end
`endif

    assign p0_gnt   = gnt0;
    assign p1_gnt   = gnt1;
    assign ram_addr = gnt0 ? p0_addr : gnt1 ? p1_addr : '0;
    assign ram_din  = gnt0 ? p0_wdata : gnt1 ? p1_wdata : '0;
    assign ram_we   = (gnt0 && p0_we) || (gnt1 && p1_we);
    assign p0_rdata = ram_dout;
    assign p1_rdata = ram_dout;
endmodule

// File: tb/tb_ram_port_arbiter_d0.sv
// tb_ram_port_arbiter_d0: scoreboard bench for ram_port_arbiter_d0 with a behavioural RAM
module tb_ram_port_arbiter_d0;
    localparam int AW = 3;
    localparam int DW = 32;
    localparam int LM = 8;
`ifdef RAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic p0_req = 1'b0, p0_we = 1'b0, p0_lock = 1'b0;
    logic p1_req = 1'b0, p1_we = 1'b0, p1_lock = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, ram_we;
    logic [DW-1:0] p0_rdata, p1_rdata, ram_din;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout = '0;

    ram_port_arbiter_d0 #(.AWIDTH(AW), .DWIDTH(DW), .LOCK_MAX(LM)) dut (
        .clock(clock), .resetn(resetn),
        .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    always #5 clock = ~clock;

    // behavioural sync-read RAM
    logic [DW-1:0] mem [8];
    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    typedef struct {int port; logic [DW-1:0] data; int due;} exp_t;
    exp_t sb[$];
    logic [DW-1:0] model_mem [8];
    int checks = 0, errors = 0, cyc = 0;
    bit started = 1'b0;
    // reference model: locked owner (-1 none), grants given under the lock, next tie winner
    int owner = -1, held = 0, pref = FIXED ? 1 : 0, last_w = -1;
    string trace = "";

    // monitor: every read-data beat must match the oldest outstanding read
    always @(posedge clock) begin
        exp_t e;
        logic [DW-1:0] got;
        cyc++;
        #1;
        if (started) begin
            if (p0_rvalid || p1_rvalid) begin
                checks++;
                got = p1_rvalid ? p1_rdata : p0_rdata;
                if (p0_rvalid && p1_rvalid) begin
                    errors++;
                    $display("FAIL rvalid_both cycle %0d: got p0_rvalid=1 p1_rvalid=1, required at most one", cyc);
                end else if (sb.size() == 0 || sb[0].due != cyc) begin
                    errors++;
                    $display("FAIL rvalid_unexpected cycle %0d: got p%0d_rvalid=1, required no read result", cyc, p1_rvalid ? 1 : 0);
                end else begin
                    e = sb.pop_front();
                    if (e.port != (p1_rvalid ? 1 : 0) || got !== e.data) begin
                        errors++;
                        $display("FAIL rdata cycle %0d: got port %0d data %h, required port %0d data %h",
                                 cyc, p1_rvalid ? 1 : 0, got, e.port, e.data);
                    end
                end
            end
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL rvalid_missing cycle %0d: got no rvalid, required p%0d_rvalid with data %h", cyc, e.port, e.data);
            end
        end
    end

    task automatic step(input logic r0, w0, l0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic r1, w1, l1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic rn);
        int w;
        logic [1:0] eg;
        logic ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        @(negedge clock);
        resetn = rn;
        p0_req = r0; p0_we = w0; p0_lock = l0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_lock = l1; p1_addr = a1; p1_wdata = d1;
        #2;
        if (!rn) w = -1;
        else if (owner >= 0) w = (owner == 0 ? r0 : r1) ? owner : -1;
        else if (r0 && r1) w = pref;
        else w = r0 ? 0 : r1 ? 1 : -1;
        eg  = w == 0 ? 2'b01 : w == 1 ? 2'b10 : 2'b00;
        ewe = w == 0 ? w0 : w == 1 ? w1 : 1'b0;
        ea  = w == 0 ? a0 : w == 1 ? a1 : '0;
        ed  = w == 0 ? d0 : w == 1 ? d1 : '0;
        checks++;
        if ({p1_gnt, p0_gnt} !== eg) begin
            errors++;
            $display("FAIL grant cycle %0d: got p1_gnt,p0_gnt=%b%b, required %b", cyc, p1_gnt, p0_gnt, eg);
        end
        checks++;
        if (ram_we !== ewe || ram_addr !== ea || ram_din !== ed) begin
            errors++;
            $display("FAIL ram_port cycle %0d: got we=%b addr=%0d din=%h, required we=%b addr=%0d din=%h",
                     cyc, ram_we, ram_addr, ram_din, ewe, ea, ed);
        end
        trace = {trace, w < 0 ? "-" : w == 1 ? "1" : "0"};
        if (w >= 0) begin
            if (ewe) model_mem[ea] = ed;
            else sb.push_back('{w, model_mem[ea], cyc + 1});
        end
        if (!rn) begin
            owner = -1; held = 0; pref = FIXED ? 1 : 0;
        end else if (owner >= 0) begin
            if ((owner == 1 ? r1 && l1 : r0 && l0) && held + 1 < LM) held++;
            else begin
                if (!FIXED && (owner == 1 ? r1 && l1 : r0 && l0)) pref = 1 - owner;
                owner = -1; held = 0;
            end
        end else if (w >= 0) begin
            if (!FIXED && r0 && r1) pref = 1 - w;
            if (w == 1 ? l1 : l0) begin owner = w; held = 1; end
        end
        last_w = rn ? w : -1;
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        trace = "";
    endtask

    task automatic expect_trace(input string name, input string want);
        checks++;
        if (trace != want) begin
            errors++;
            $display("FAIL %s: got grant sequence %s, required %s", name, trace, want);
        end
        trace = "";
    endtask

    logic rr[2], rw[2], rl[2];
    logic [AW-1:0] ra[2];
    logic [DW-1:0] rd[2];
    logic rrn = 1'b1;

    initial begin
        for (int i = 0; i < 8; i++) begin
            mem[i] = 32'hA5A5_0000 + DW'(i);
            model_mem[i] = 32'hA5A5_0000 + DW'(i);
        end
        // reset with both ports requesting
        trace = "";
        step(1, 0, 0, 1, 0, 1, 0, 0, 2, 0, 0);
        started = 1'b1;
        step(1, 0, 0, 1, 0, 1, 0, 0, 2, 0, 0);
        expect_trace("reset_no_grant", "--");
        // single read of address 3
        do_reset();
        step(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        expect_trace("single_read", "0-");
        // tie, both reading every cycle
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0, 1, 0, 0, 2, 0, 1);
        expect_trace("tie", FIXED ? "1111" : "0101");
        // locked write then read of address 5 while port 1 waits
        do_reset();
        step(1, 1, 1, 5, 32'h11, 1, 0, 0, 6, 0, 1);
        step(1, 0, 0, 5, 0, 1, 0, 0, 6, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 0, 6, 0, 1);
        expect_trace("lock_rmw", FIXED ? "111" : "001");
        // lock timeout with port 1 waiting
        do_reset();
        for (int i = 0; i < 12; i++) step(1, 0, 1, 1, 0, 1, 0, 0, 2, 0, 1);
        expect_trace("lock_timeout", FIXED ? "111111111111" : "000000001000");
        // randomized traffic; an ungranted requester holds its request
        for (int i = 0; i < 2; i++) rr[i] = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!(rr[i] && rrn && last_w != i)) begin
                    rr[i] = $urandom_range(0, 3) != 0;
                    rw[i] = $urandom_range(0, 2) == 0;
                    rl[i] = $urandom_range(0, 3) != 0;
                    ra[i] = AW'($urandom_range(0, 7));
                    rd[i] = $urandom;
                end
            end
            rrn = $urandom_range(0, 80) != 0;
            step(rr[0], rw[0], rl[0], ra[0], rd[0], rr[1], rw[1], rl[1], ra[1], rd[1], rrn);
            if (!rrn) rr[0] = 1'b0;
            if (!rrn) rr[1] = 1'b0;
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clock);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding reads, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
